// File: rtl/matrix_mac_mult.sv
// Sequential matrix multiplier C = A x B, one multiply-accumulate per clock.
// Operands are captured on start; results narrow by saturation or wrap.
module matrix_mac_mult #(
    parameter int M          = 3,
    parameter int K          = 3,
    parameter int N          = 3,
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 16,
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 1
) (
    input  logic                          clk,
    input  logic                          i_rst_n,
    input  logic                          i_calc,
    input  logic [M*K*DATA_WIDTH-1:0]     i_matrix_1,
    input  logic [K*N*DATA_WIDTH-1:0]     i_matrix_2,
    output logic [M*N*RES_WIDTH-1:0]      o_result,
    output logic                          o_busy,
    output logic                          o_ready
);

    localparam int ACC_W = 2*DATA_WIDTH + $clog2(K) + 1;
    localparam int IW    = (M > 1) ? $clog2(M) : 1;
    localparam int JW    = (N > 1) ? $clog2(N) : 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(M-1);
    localparam logic [JW-1:0] J_LAST = JW'(N-1);
    localparam logic [KW-1:0] K_LAST = KW'(K-1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         i_q, i_d;
    logic [JW-1:0]         j_q, j_d;
    logic [KW-1:0]         k_q, k_d;
    logic [ACC_W-1:0]      acc_q, acc_d;

    logic [DATA_WIDTH-1:0] a_q [M][K];
    logic [DATA_WIDTH-1:0] b_q [K][N];
    logic [RES_WIDTH-1:0]  c_q [M][N];

    logic                  capture;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] a_sel, b_sel;
    logic [ACC_W-1:0]      a_ext, b_ext, prod, sum;
    logic [RES_WIDTH-1:0]  narrowed;

    // Operands are extended to the accumulator width before multiplying,
    // so the truncated product is exact for both signed and unsigned modes.
    always_comb begin
        a_sel = a_q[i_q][k_q];
        b_sel = b_q[k_q][j_q];
        if (SIGNED != 0) begin
            a_ext = ACC_W'($signed(a_sel));
            b_ext = ACC_W'($signed(b_sel));
        end else begin
            a_ext = ACC_W'(a_sel);
            b_ext = ACC_W'(b_sel);
        end
        prod = a_ext * b_ext;
        sum  = acc_q + prod;
    end

    generate
        if (RES_WIDTH < ACC_W) begin : g_narrow
            always_comb begin
                narrowed = sum[RES_WIDTH-1:0];
                if (SATURATE != 0) begin
                    if (SIGNED != 0) begin
                        if (sum[ACC_W-1:RES_WIDTH-1] != {(ACC_W-RES_WIDTH+1){sum[ACC_W-1]}}) begin
                            narrowed = sum[ACC_W-1] ? {1'b1, {(RES_WIDTH-1){1'b0}}}
                                                    : {1'b0, {(RES_WIDTH-1){1'b1}}};
                        end
                    end else if (sum[ACC_W-1:RES_WIDTH] != '0) begin
                        narrowed = '1;
                    end
                end
            end
        end else begin : g_extend
            always_comb begin
                if (SIGNED != 0) begin
                    narrowed = RES_WIDTH'($signed(sum));
                end else begin
                    narrowed = RES_WIDTH'(sum);
                end
            end
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        capture  = 1'b0;
        write_en = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_calc) begin
                    capture = 1'b1;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (k_q != K_LAST) begin
                    acc_d = sum;
                    k_d   = k_q + 1'b1;
                end else begin
                    write_en = 1'b1;
                    acc_d    = '0;
                    k_d      = '0;
                    if (j_q != J_LAST) begin
                        j_d = j_q + 1'b1;
                    end else begin
                        j_d = '0;
                        if (i_q != I_LAST) begin
                            i_d = i_q + 1'b1;
                        end else begin
                            i_d     = '0;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned r = 0; r < M; r++)
                for (int unsigned c = 0; c < K; c++)
                    a_q[r][c] <= '0;
            for (int unsigned r = 0; r < K; r++)
                for (int unsigned c = 0; c < N; c++)
                    b_q[r][c] <= '0;
        end else if (capture) begin
            for (int unsigned r = 0; r < M; r++)
                for (int unsigned c = 0; c < K; c++)
                    a_q[r][c] <= i_matrix_1[(r*K+c)*DATA_WIDTH +: DATA_WIDTH];
            for (int unsigned r = 0; r < K; r++)
                for (int unsigned c = 0; c < N; c++)
                    b_q[r][c] <= i_matrix_2[(r*N+c)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Elements not yet rewritten in a new run keep their previous values.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned r = 0; r < M; r++)
                for (int unsigned c = 0; c < N; c++)
                    c_q[r][c] <= '0;
        end else if (write_en) begin
            c_q[i_q][j_q] <= narrowed;
        end
    end

    generate
        for (genvar r = 0; r < M; r++) begin : g_row
            for (genvar c = 0; c < N; c++) begin : g_col
                assign o_result[(r*N+c)*RES_WIDTH +: RES_WIDTH] = c_q[r][c];
            end
        end
    endgenerate

    assign o_busy  = (state_q == S_CALC);
    assign o_ready = (state_q == S_DONE);

endmodule

// File: tb/tb_matrix_mac_mult.sv
// Scoreboard bench for matrix_mac_mult: three configurations driven with random
// and corner operands, checked against an integer matrix-product model.
module tb_matrix_mac_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  calc;
    logic [71:0] a0, b0, a1, b1;
    logic [63:0] a2;
    logic [95:0] b2;
    logic [143:0] r0, r1;
    logic [95:0]  r2;
    logic [2:0]  busy, ready;

    // u0: 3x3x3 unsigned saturating, u1: 3x3x3 signed saturating,
    // u2: 2x4x3 unsigned wrapping
    matrix_mac_mult u0 (
        .clk(clk), .i_rst_n(rst_n), .i_calc(calc[0]), .i_matrix_1(a0), .i_matrix_2(b0),
        .o_result(r0), .o_busy(busy[0]), .o_ready(ready[0]));
    matrix_mac_mult #(.SIGNED(1), .SATURATE(1)) u1 (
        .clk(clk), .i_rst_n(rst_n), .i_calc(calc[1]), .i_matrix_1(a1), .i_matrix_2(b1),
        .o_result(r1), .o_busy(busy[1]), .o_ready(ready[1]));
    matrix_mac_mult #(.M(2), .K(4), .N(3), .SATURATE(0)) u2 (
        .clk(clk), .i_rst_n(rst_n), .i_calc(calc[2]), .i_matrix_1(a2), .i_matrix_2(b2),
        .o_result(r2), .o_busy(busy[2]), .o_ready(ready[2]));

    function automatic int dm(int n); return (n == 2) ? 2 : 3; endfunction
    function automatic int dk(int n); return (n == 2) ? 4 : 3; endfunction
    function automatic int dn(int n); return 3; endfunction
    function automatic bit sg(int n); return (n == 1); endfunction
    function automatic bit sat(int n); return (n != 2); endfunction

    typedef struct packed {
        int           start;
        int           done;
        logic [143:0] c;
    } exp_t;

    exp_t sq [3][$];
    logic [7:0] ga [4][4];
    logic [7:0] gb [4][4];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    logic [2:0] prev_rdy = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    // Plain integer dot product followed by the narrowing rule.
    function automatic logic [15:0] ref_elem(int n, int r, int c);
        longint s, x, y;
        s = 0;
        for (int k = 0; k < dk(n); k++) begin
            x = longint'(ga[r][k]);
            y = longint'(gb[k][c]);
            if (sg(n)) begin
                if (x >= 128) x -= 256;
                if (y >= 128) y -= 256;
            end
            s += x * y;
        end
        if (sat(n)) begin
            if (sg(n)) begin
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
            end else if (s > 65535) begin
                s = 65535;
            end
        end
        return s[15:0];
    endfunction

    function automatic logic [15:0] elem(int n, int e);
        case (n)
            0:       return r0[e*16 +: 16];
            1:       return r1[e*16 +: 16];
            default: return r2[e*16 +: 16];
        endcase
    endfunction

    function automatic logic [7:0] rnd8();
        case ($urandom_range(0, 4))
            0:       return 8'd0;
            1:       return 8'hFF;
            2:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ga[r][c] = rnd8();
                gb[r][c] = rnd8();
            end
    endtask

    task automatic fill_const(input logic [7:0] av, input logic [7:0] bv);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ga[r][c] = av;
                gb[r][c] = bv;
            end
    endtask

    // Drives buses from ga/gb, pushes the expected result, pulses (or holds) i_calc.
    task automatic issue(input int n, input bit hold);
        exp_t e;
        int   lat;
        for (int r = 0; r < dm(n); r++)
            for (int c = 0; c < dk(n); c++)
                case (n)
                    0:       a0[(r*dk(n)+c)*8 +: 8] = ga[r][c];
                    1:       a1[(r*dk(n)+c)*8 +: 8] = ga[r][c];
                    default: a2[(r*dk(n)+c)*8 +: 8] = ga[r][c];
                endcase
        for (int r = 0; r < dk(n); r++)
            for (int c = 0; c < dn(n); c++)
                case (n)
                    0:       b0[(r*dn(n)+c)*8 +: 8] = gb[r][c];
                    1:       b1[(r*dn(n)+c)*8 +: 8] = gb[r][c];
                    default: b2[(r*dn(n)+c)*8 +: 8] = gb[r][c];
                endcase
        lat     = dm(n) * dn(n) * dk(n);
        e.start = cyc + 1;
        e.done  = e.start + lat;
        e.c     = '0;
        for (int r = 0; r < dm(n); r++)
            for (int c = 0; c < dn(n); c++)
                e.c[(r*dn(n)+c)*16 +: 16] = ref_elem(n, r, c);
        sq[n].push_back(e);
        if (hold) begin
            e.start = e.done + 1;
            e.done  = e.start + lat;
            sq[n].push_back(e);
        end
        calc[n] = 1'b1;
        step();
        if (!hold) calc[n] = 1'b0;
    endtask

    task automatic issue_all();
        for (int n = 0; n < 3; n++) issue(n, 1'b0);
    endtask

    task automatic wait_all();
        int t;
        t = 0;
        while ((sq[0].size() != 0 || sq[1].size() != 0 || sq[2].size() != 0) && t < 500) begin
            step();
            t++;
        end
        if (t >= 500) begin
            chk("completion_timeout", 64'd1, 64'd0);
            for (int n = 0; n < 3; n++) sq[n].delete();
        end
    endtask

    // Monitor: checks busy every cycle, each C element on its write edge, and
    // the full result plus completion cycle whenever o_ready rises.
    always @(negedge clk) begin
        bit   eb;
        int   e;
        exp_t f;
        if (!rst_n) begin
            prev_rdy <= '0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                eb = (sq[n].size() != 0) && (cyc >= sq[n][0].start) && (cyc < sq[n][0].done);
                chk($sformatf("busy%0d", n), 64'(busy[n]), 64'(eb));
                if (ready[n] && busy[n]) chk($sformatf("busy_and_ready%0d", n), 64'd1, 64'd0);
                if (sq[n].size() != 0 && cyc > sq[n][0].start && cyc <= sq[n][0].done &&
                    ((cyc - sq[n][0].start) % dk(n)) == 0) begin
                    e = (cyc - sq[n][0].start) / dk(n) - 1;
                    chk($sformatf("write%0d_e%0d", n, e), 64'(elem(n, e)),
                        64'(sq[n][0].c[e*16 +: 16]));
                end
                if (ready[n] && !prev_rdy[n]) begin
                    if (sq[n].size() == 0) begin
                        chk($sformatf("unexpected_ready%0d", n), 64'd1, 64'd0);
                    end else begin
                        f = sq[n].pop_front();
                        chk($sformatf("ready_cycle%0d", n), 64'(cyc), 64'(f.done));
                        for (int k = 0; k < dm(n) * dn(n); k++)
                            chk($sformatf("result%0d_e%0d", n, k), 64'(elem(n, k)),
                                64'(f.c[k*16 +: 16]));
                    end
                end
            end
            prev_rdy <= ready;
        end
    end

    initial begin
        int t0;
        rst_n = 1'b0;
        calc  = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (3) step();
        chk("reset_flags", 64'({busy, ready}), 64'd0);
        chk("reset_results", 64'({|r0, |r1, |r2}), 64'd0);
        rst_n = 1'b1;
        step();

        // Identity A, B = 1..N row-major
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ga[r][c] = (r == c) ? 8'd1 : 8'd0;
                gb[r][c] = 8'(r*4 + c + 1);
            end
        issue_all();
        wait_all();

        // Saturation / wrap extremes
        fill_const(8'hFF, 8'hFF);
        issue_all();
        wait_all();
        fill_const(8'h80, 8'h80);
        issue_all();
        wait_all();
        fill_const(8'hFF, 8'h05);
        issue_all();
        wait_all();

        // Capture isolation and busy-ignore of i_calc
        fill_rand();
        t0 = cyc + 1;
        issue(0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            a0[i*8 +: 8] = 8'($urandom);
            b0[i*8 +: 8] = 8'($urandom);
        end
        while (cyc < t0 + 9) step();
        calc[0] = 1'b1;
        step();
        calc[0] = 1'b0;
        wait_all();

        // i_calc held through DONE: back-to-back runs
        fill_rand();
        t0 = cyc + 1;
        issue(0, 1'b1);
        while (cyc < t0 + 28) step();
        calc[0] = 1'b0;
        wait_all();

        // Reset in the middle of a run
        fill_rand();
        issue_all();
        repeat (10) step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_flags", 64'({busy, ready}), 64'd0);
        chk("midreset_results", 64'({|r0, |r1, |r2}), 64'd0);
        for (int n = 0; n < 3; n++) sq[n].delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        fill_rand();
        issue_all();
        wait_all();

        // Randomised runs, restarting straight from DONE
        for (int it = 0; it < 10; it++) begin
            fill_rand();
            issue_all();
            wait_all();
        end

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_mac_mult.md
# matrix_mac_mult

Parametrised sequential matrix multiplier computing C = A × B, where A is M×K and B is K×N, with one multiply-accumulate per clock. It succeeds the fixed-size matrix_mult_matrix block and adds:
- configurable dimensions and element width;
- signed or unsigned arithmetic;
- a widened accumulator with saturating or wrapping result narrowing;
- a defined start/ready handshake.

It sits between the operand register banks and the result consumer in the matrix_ops datapath.

## Interface
- M, 3, rows of A and C
- K, 3, columns of A / rows of B (inner dimension), ≥1
- N, 3, columns of B and C
- DATA_WIDTH, 8, bits per A/B element
- RES_WIDTH, 16, bits per C element
- SIGNED, 0, 1 = two's-complement operands and result, 0 = unsigned
- SATURATE, 1, 1 = clamp result to RES_WIDTH range, 0 = keep low RES_WIDTH bits
- clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_calc  in  1  start request, sampled when idle or done
- i_matrix_1  in  M*K*DATA_WIDTH  A, element (r,c) at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]
- i_matrix_2  in  K*N*DATA_WIDTH  B, element (r,c) at bits [(r*N+c)*DATA_WIDTH +: DATA_WIDTH]
- o_result  out  M*N*RES_WIDTH  C, element (r,c) at bits [(r*N+c)*RES_WIDTH +: RES_WIDTH]
- o_busy  out  1  computation in progress
- o_ready  out  1  o_result complete and valid

## Operation
- Reset (async, i_rst_n=0):
  - state=IDLE;
  - counters i,j,k, the accumulator and all captured operands cleared;
  - o_result=0, o_busy=0, o_ready=0.
- States: IDLE, CALC, DONE.
- IDLE or DONE with i_calc=1:
  - capture i_matrix_1 and i_matrix_2 into internal registers;
  - clear i,j,k and the accumulator;
  - go to CALC, with o_busy=1 and o_ready=0.
- Input buses may change after the capture edge; the computation uses only the captured copies.
- CALC, each cycle:
  - prod = A[i][k] × B[k][j], full 2*DATA_WIDTH bits, signedness per SIGNED;
  - sum = acc + prod;
  - ACC_WIDTH = 2*DATA_WIDTH + clog2(K) + 1, which is never lost.
  - If k < K-1: acc <= sum, k++.
  - If k = K-1:
    - C[i][j] <= narrow(sum);
    - acc <= 0, k <= 0;
    - advance j, wrapping to 0 and incrementing i;
    - after element (M-1,N-1): go to DONE, with o_busy=0 and o_ready=1.
- narrow():
  - SATURATE=1, unsigned: values >2^RES_WIDTH−1 become 2^RES_WIDTH−1.
  - SATURATE=1, signed: clamp to [−2^(RES_WIDTH−1), 2^(RES_WIDTH−1)−1].
  - SATURATE=0: low RES_WIDTH bits, two's-complement wrap.
- i_calc while in CALC is ignored; no restart and no queueing.
- DONE holds o_ready=1 and o_result stable indefinitely until the next i_calc.
- o_result elements update one by one during CALC and are valid only while o_ready=1. Elements not yet rewritten keep their previous values.

## Timing
- Capture edge T (i_calc=1 in IDLE/DONE): o_busy=1 and o_ready=0 from T.
- MAC edges: T+1 … T+M*N*K.
- C element (r,c) is written at edge T+((r*N+c)+1)*K.
- o_ready=1 and o_busy=0 from edge T+M*N*K; latency is M*N*K cycles, 27 at defaults.
- i_calc in DONE at edge D drops o_ready at D and restarts; back-to-back operations need no idle cycle.
- i_calc is level-sampled; holding it high in DONE restarts every completion.
- Reset mid-CALC aborts immediately: outputs return to reset values, and no partial o_ready ever appears.
- o_busy and o_ready are never both 1.

## Test plan
- Identity: A = I (defaults), B = 1..9 row-major, i_calc one cycle -> after exactly 27 cycles o_ready=1, C = 1..9; o_busy high for cycles 1..27 only.
- Unsigned saturation: all elements 255, SATURATE=1 -> every C = 65535. SATURATE=0 -> every C = 64003 (195075 mod 65536).
- Signed: SIGNED=1, A all −128, B all −128 -> C = 32767 with saturation. A all −1, B all 5 -> C = −15 (0xFFF1).
- Busy ignore and capture: pulse i_calc again at cycle 10 and change the input buses at cycle 2 -> completion still at cycle 27, with results from the originally captured operands.
- Back-to-back: i_calc held high through DONE -> o_ready high one cycle, then low, and the second result is ready 27 cycles later.
- Reset mid-operation: assert i_rst_n=0 at cycle 13 -> o_result=0, o_busy=0, o_ready=0 asynchronously. A new i_calc after release completes correctly in 27 cycles.
- Non-square: M=2, K=4, N=3 -> latency 24; C[1][2] written at edge T+24; all products match the software reference.
